// File: rtl/pipe_pkg.sv
// Shared definitions for the ID-stage hazard/stall logic.
package pipe_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    HOLD2 = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         MD_CYCLES_DEF = 32;

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div occupancy timer: loads on an accepted start, counts down to zero.
module md_busy_counter #(
  parameter int MD_CYCLES = 32,
  parameter int MD_CNT_W  = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic md_busy
);

  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - 1'b1;
    else if (start)
      md_cnt_d = MD_CNT_W'(MD_CYCLES - 1);
  end

  always_ff @(posedge clk) begin
    if (reset) md_cnt_q <= '0;
    else       md_cnt_q <= md_cnt_d;
  end

  assign md_busy = (md_cnt_q != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detection: load-use, branch operand and mult/div stalls.
// state | meaning
// RUN   | normal issue; stall only on a detected hazard
// HOLD2 | second stall cycle for a branch that depends on a load
module hazard_stall_unit
  import pipe_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF,
  parameter int MD_CNT_W  = 6,
  parameter int STAT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        id_instr_rs,
  input  logic [4:0]        id_instr_rt,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic              id_branch_taken,
  input  logic              id_md_start,
  input  logic              id_reads_hilo,
  input  logic              id_ex_mem_read,
  input  logic              id_ex_reg_write,
  input  logic [4:0]        id_ex_write_reg_addr,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic              md_busy,
  output logic [STAT_W-1:0] stall_cycles
);

  hz_state_e         state_q, state_d;
  logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic              match_rs, match_rt, load_use, br_alu, br_load, md_hz;
  logic              stall;

  always_comb begin
    match_rs = (id_ex_write_reg_addr != REG_ZERO) && (id_ex_write_reg_addr == id_instr_rs);
    match_rt = (id_ex_write_reg_addr != REG_ZERO) && id_uses_rt
               && (id_ex_write_reg_addr == id_instr_rt);
    load_use = id_ex_mem_read && (match_rs || match_rt);
    br_alu   = id_is_branch && id_ex_reg_write && !id_ex_mem_read && (match_rs || match_rt);
    br_load  = id_is_branch && load_use;
    md_hz    = md_busy && (id_md_start || id_reads_hilo);
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      RUN: begin
        stall = load_use || br_alu || md_hz;
        if (br_load) state_d = HOLD2;
      end
      HOLD2: begin
        stall   = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Reset looks like a permanent stall to the pipeline and never flushes.
  always_comb begin
    pc_write     = !stall;
    if_id_write  = !stall;
    id_ex_bubble = stall;
    if_id_flush  = id_is_branch && id_branch_taken && !stall;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b0;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // A stalled (bubbled) mult/div must not start the unit.
  md_busy_counter #(
    .MD_CYCLES (MD_CYCLES),
    .MD_CNT_W  (MD_CNT_W)
  ) u_md_busy_counter (
    .clk     (clk),
    .reset   (reset),
    .start   (id_md_start && !stall),
    .md_busy (md_busy)
  );

  assign stall_cycles = stall_cycles_q;

endmodule
